// File: rtl/mpemu_pkg.sv
// Shared definitions for the pipelined signed fixed-point multiplier.
// Holds the rounding-mode encodings and the full-product width helper.
package mpemu_pkg;

  // Encodings of the round_i input.
  localparam logic RND_TRUNC  = 1'b0;  // floor after the arithmetic shift
  localparam logic RND_HALFUP = 1'b1;  // add half an LSB before the shift

  // Width of the exact signed product of two signed operands.
  function automatic int full_prod_w(input int cand_w, input int plier_w);
    return cand_w + plier_w;
  endfunction

endpackage

// File: rtl/mpemu_pipe_delay.sv
// mpemu_delay: clock-enabled, synchronously reset shift register.
// Carries the {valid, tag, data, ovf} bundle through the multiplier pipeline.
// Stage 0 captures the input; stage DEPTH-1 drives the output.
module mpemu_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the bundle one stage per enabled edge; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage is reset, not just the output, so in-flight samples
      // are discarded; these are pipeline flops, not a RAM array.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (ce) begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, which is what gives a true shift register.
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mpemu_pipe.sv
// mpemu_pipe: parametrised pipelined signed fixed-point multiplier.
// Full product -> optional half-up rounding -> arithmetic shift -> narrow,
// all combinational ahead of stage 0, then LATENCY-1 pure delay stages.
// Optional feature macro: MPEMU_SAT_EN (saturate instead of wrap, drive ovf_o).
module mpemu_pipe
  import mpemu_pkg::*;
#(
  parameter int CAND_W     = 24,
  parameter int PLIER_W    = 16,
  parameter int PROD_W     = 24,
  parameter int FRAC_SHIFT = 15,
  parameter int LATENCY    = 4,
  parameter int TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              valid_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              round_i,
  input  logic [CAND_W-1:0] mpcand_i,
  input  logic [PLIER_W-1:0] mplier_i,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [PROD_W-1:0] mprod_o,
  output logic              ovf_o
);

  localparam int FULL_W = full_prod_w(CAND_W, PLIER_W);
  // One guard bit so adding the rounding bias can never overflow.
  localparam int EXT_W  = FULL_W + 1;
  // Half an output LSB; evaluates to zero when FRAC_SHIFT is 0, so round_i
  // has no effect in that configuration.
  localparam logic signed [EXT_W-1:0] RND_BIAS = (EXT_W'(1) << FRAC_SHIFT) >> 1;

  logic signed [FULL_W-1:0] full_p;
  logic signed [EXT_W-1:0]  biased;
  logic [PROD_W-1:0]        data_d;

  assign full_p = FULL_W'($signed(mpcand_i)) * FULL_W'($signed(mplier_i));
  assign biased = EXT_W'(full_p) + ((round_i == RND_HALFUP) ? RND_BIAS : '0);

`ifdef MPEMU_SAT_EN
  localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) <<< (PROD_W-1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -(EXT_W'(1) <<< (PROD_W-1));
  localparam int BUNDLE_W = 1 + TAG_W + PROD_W + 1;

  logic signed [EXT_W-1:0] shifted;
  logic                    ovf_d;
  logic [BUNDLE_W-1:0]     bundle_q;

  assign shifted = biased >>> FRAC_SHIFT;

  // Clamp the shifted result into the signed PROD_W range and flag it.
  always_comb begin
    // NOTE: both outputs get a default before any branch so no latch is inferred.
    data_d = shifted[PROD_W-1:0];
    ovf_d  = 1'b0;
    if (shifted > SAT_MAX) begin
      data_d = SAT_MAX[PROD_W-1:0];
      ovf_d  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      data_d = SAT_MIN[PROD_W-1:0];
      ovf_d  = 1'b1;
    end
  end

  mpemu_delay #(.WIDTH(BUNDLE_W), .DEPTH(LATENCY)) u_delay (
    .clk (clk),
    .rst (rst),
    .ce  (ce_i),
    .d   ({valid_i, tag_i, data_d, ovf_d}),
    .q   (bundle_q)
  );

  assign {valid_o, tag_o, mprod_o, ovf_o} = bundle_q;
`else
  localparam int BUNDLE_W = 1 + TAG_W + PROD_W;

  logic [BUNDLE_W-1:0] bundle_q;

  // Wrap: keep the low PROD_W bits of the arithmetically shifted value.
  assign data_d = PROD_W'(biased >>> FRAC_SHIFT);

  mpemu_delay #(.WIDTH(BUNDLE_W), .DEPTH(LATENCY)) u_delay (
    .clk (clk),
    .rst (rst),
    .ce  (ce_i),
    .d   ({valid_i, tag_i, data_d}),
    .q   (bundle_q)
  );

  assign {valid_o, tag_o, mprod_o} = bundle_q;
  assign ovf_o = 1'b0;
`endif

endmodule
